// File: rtl/riscvboy_bus_arb.sv
// riscvboy_bus_arb: N-channel memory request arbiter for the riscvBoy core.
// Merges instruction-fetch, data and auxiliary requestors onto one shared
// memory port. It supports fixed or round-robin priority, a fixed-latency
// read-return pipeline that routes data back to the issuing channel, and a
// same-cycle grant handshake.
// Optional feature macro: RISCVBOY_ARB_ANTISTARVE_EN. When it is defined,
// per-channel wait counters give a channel that has waited STARVE_LIM cycles
// absolute priority.
module riscvboy_bus_arb #(
    parameter int NCH        = 2,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int PRIO_MODE  = 0,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic [NCH-1:0]    i_req,
    input  logic [NCH-1:0]    i_we,
    input  logic [NCH*DW/8-1:0] i_wbe,
    input  logic [NCH*AW-1:0] i_addr,
    input  logic [NCH*DW-1:0] i_wdata,
    output logic [NCH-1:0]    o_gnt,
    output logic [NCH-1:0]    o_rvalid,
    output logic [DW-1:0]     o_rdata,
    output logic              o_mem_ren,
    output logic              o_mem_wen,
    output logic [DW/8-1:0]   o_mem_wbe,
    output logic [AW-1:0]     o_mem_addr,
    output logic [DW-1:0]     o_mem_wdata,
    input  logic [DW-1:0]     i_mem_rdata
);

    localparam int BW = DW / 8;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    // Reject configurations outside the supported range at elaboration.
    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $error("riscvboy_bus_arb: NCH must be 1..8");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("riscvboy_bus_arb: RD_LAT must be 1..4");
    end
    if ((DW % 8) != 0) begin : g_bad_dw
        $error("riscvboy_bus_arb: DW must be a multiple of 8");
    end
    if (PRIO_MODE != 0 && PRIO_MODE != 1) begin : g_bad_prio
        $error("riscvboy_bus_arb: PRIO_MODE must be 0 or 1");
    end
    if (STARVE_LIM < 2 || STARVE_LIM > 255) begin : g_bad_starve
        $error("riscvboy_bus_arb: STARVE_LIM must be 2..255");
    end

    // Round-robin pointer: the channel that has the highest priority this cycle.
    logic [CW-1:0] ptr;
    logic [CW-1:0] ptr_nxt;

    // Winner of this cycle's arbitration.
    logic          win_vld;
    logic [CW-1:0] win_idx;
    logic          win_we;

    // Read-return pipeline. Stage 0 is loaded at grant and the last stage
    // routes the memory data back to the issuing channel.
    logic [RD_LAT-1:0] vld_p;
    logic [CW-1:0]     ch_p [RD_LAT];

`ifdef RISCVBOY_ARB_ANTISTARVE_EN
    logic [7:0] wait_cnt [NCH];
`endif

    // Pick the winner: a starving channel first (when enabled), then fixed or rotating priority.
    always_comb begin : arb_comb
        int idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
`ifdef RISCVBOY_ARB_ANTISTARVE_EN
        for (int i = 0; i < NCH; i++) begin
            if (!win_vld && i_req[i] && (wait_cnt[i] >= 8'(STARVE_LIM))) begin
                win_vld = 1'b1;
                win_idx = CW'(i);
            end
        end
`endif
        if (PRIO_MODE == 0) begin
            for (int i = 0; i < NCH; i++) begin
                if (!win_vld && i_req[i]) begin
                    win_vld = 1'b1;
                    win_idx = CW'(i);
                end
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                idx = (int'(ptr) + i) % NCH;
                if (!win_vld && i_req[idx]) begin
                    win_vld = 1'b1;
                    win_idx = CW'(idx);
                end
            end
        end
        // No command may be issued while the block is held in reset.
        if (rst) begin
            win_vld = 1'b0;
            win_idx = '0;
        end
    end

    // Build the one-hot grant and the shared memory command from the winner.
    always_comb begin : cmd_comb
        o_gnt       = '0;
        win_we      = 1'b0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_wbe   = '0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        for (int i = 0; i < NCH; i++) begin
            o_gnt[i] = win_vld && (win_idx == CW'(i));
        end
        if (win_vld) begin
            win_we      = i_we[win_idx];
            o_mem_ren   = ~win_we;
            o_mem_wen   = win_we;
            o_mem_wbe   = win_we ? i_wbe[win_idx*BW +: BW] : '0;
            o_mem_addr  = i_addr[win_idx*AW +: AW];
            o_mem_wdata = i_wdata[win_idx*DW +: DW];
        end
    end

    // The pointer moves to the channel after the one just granted. It wraps at NCH.
    always_comb begin : ptr_comb
        ptr_nxt = (win_idx == CW'(NCH - 1)) ? '0 : win_idx + CW'(1);
    end

    // Pointer register. It holds when no grant is issued.
    always_ff @(posedge clk_sys) begin : ptr_ff
        if (rst) begin
            ptr <= '0;
        end else if (win_vld) begin
            ptr <= ptr_nxt;
        end
    end

    // Return pipeline valid bits. Reset discards every read in flight.
    always_ff @(posedge clk_sys) begin : ret_vld_ff
        if (rst) begin
            vld_p <= '0;
        end else begin
            // p0: a granted read enters the pipeline
            vld_p[0] <= win_vld & ~win_we;
            // p1..pN: shift toward the return stage
            for (int s = 1; s < RD_LAT; s++) begin
                vld_p[s] <= vld_p[s-1];
            end
        end
    end

    // Return pipeline channel ids. They are qualified by vld_p, so no reset is needed.
    always_ff @(posedge clk_sys) begin : ret_ch_ff
        ch_p[0] <= win_idx;
        for (int s = 1; s < RD_LAT; s++) begin
            ch_p[s] <= ch_p[s-1];
        end
    end

    // Route the final-stage read data to its channel. Nothing is returned during reset.
    always_comb begin : rsp_comb
        o_rvalid = '0;
        for (int i = 0; i < NCH; i++) begin
            o_rvalid[i] = ~rst & vld_p[RD_LAT-1] & (ch_p[RD_LAT-1] == CW'(i));
        end
        o_rdata = i_mem_rdata;
    end

`ifdef RISCVBOY_ARB_ANTISTARVE_EN
    // Wait counters count ungranted request cycles and saturate at 255.
    always_ff @(posedge clk_sys) begin : starve_ff
        for (int i = 0; i < NCH; i++) begin
            if (rst || !i_req[i] || o_gnt[i]) begin
                wait_cnt[i] <= 8'd0;
            end else if (wait_cnt[i] != 8'hFF) begin
                wait_cnt[i] <= wait_cnt[i] + 8'd1;
            end
        end
    end
`endif

endmodule
